// File: rtl/latch_tx_pkg.sv
// Shared types and helpers for the latch-port serial transmitter.
package latch_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } tx_state_t;

    localparam int unsigned DEF_SETUP_CYC  = 1;
    localparam int unsigned DEF_STROBE_CYC = 1;
    localparam int unsigned DEF_HOLD_CYC   = 1;

    // Cycles from one accepted word to the next when words are offered back to back.
    function automatic int unsigned word_period(input int unsigned width,
                                                input int unsigned s,
                                                input int unsigned t,
                                                input int unsigned h);
        return width * (s + t + h) + 1;
    endfunction

    // Counter width able to hold max_val-1 (never narrower than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/latch_tx_phase_timer.sv
// Loadable down-counter with zero flag, timing the SETUP/STROBE/HOLD phases.
module latch_tx_phase_timer #(
    parameter int unsigned CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          zero
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/latch_strobe_tx.sv
// Serializes a handshaked word onto a data line plus level enable strobe,
// keeping data stable across setup, strobe and hold of every bit.
module latch_strobe_tx
    import latch_tx_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC,
    parameter int unsigned MSB_FIRST  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_a,
    output logic             o_en,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned MAX_PH = (SETUP_CYC > STROBE_CYC)
                                   ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                   : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int unsigned CW = cnt_width(MAX_PH);
    localparam int unsigned BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYC - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] FULL_CNT  = BW'(WIDTH);

    tx_state_t        state, next_state;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [BW-1:0]    bit_cnt, bit_cnt_d;
    logic             handshake;
    logic             tmr_load, tmr_zero;
    logic [CW-1:0]    tmr_val;
    logic             ready_d, a_d, en_d, busy_d, done_d;

    assign handshake = i_valid & o_ready;

    latch_tx_phase_timer #(.CW(CW)) u_timer (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            o_ready <= 1'b0;
            o_a     <= 1'b0;
            o_en    <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state   <= next_state;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            o_ready <= ready_d;
            o_a     <= a_d;
            o_en    <= en_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (handshake) next_state = SETUP;
            SETUP:   if (tmr_zero) next_state = STROBE;
            STROBE:  if (tmr_zero) next_state = HOLD;
            HOLD:    if (tmr_zero) next_state = (bit_cnt == LAST_BIT) ? DONE : SETUP;
            DONE:    next_state = handshake ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are computed from next_state so they can be registered
    // while still lining up with the state they describe.
    always_comb begin
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        if (handshake) begin
            shreg_d   = i_data;
            bit_cnt_d = '0;
        end else if (state == HOLD && tmr_zero) begin
            shreg_d = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
            if (bit_cnt != FULL_CNT) bit_cnt_d = bit_cnt + 1'b1;
        end

        tmr_load = (next_state != state);
        case (next_state)
            SETUP:   tmr_val = SETUP_LD;
            STROBE:  tmr_val = STROBE_LD;
            HOLD:    tmr_val = HOLD_LD;
            default: tmr_val = '0;
        endcase

        ready_d = (next_state == IDLE) || (next_state == DONE);
        busy_d  = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);
        en_d    = (next_state == STROBE);
        done_d  = (next_state == DONE);
        a_d     = busy_d & ((MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0]);
    end

    localparam int unsigned WORD_PERIOD = word_period(WIDTH, SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int unsigned PW = $clog2(WORD_PERIOD + 1);

    logic [PW-1:0] period_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            period_cnt <= '0;
        end else if (handshake) begin
            period_cnt <= PW'(1);
        end else if (period_cnt != '1) begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && o_done) begin
            assert (period_cnt == PW'(WORD_PERIOD))
                else $error("o_done at wrong distance from handshake");
        end
    end

    assert property (@(posedge i_clk) disable iff (!i_rst_n)
                     (o_en && $past(o_en)) |-> (o_a == $past(o_a)));
    assert property (@(posedge i_clk) disable iff (!i_rst_n) o_en |-> o_busy);

endmodule

// File: tb/tb_latch_strobe_tx.sv
// Randomized self-checking bench for latch_strobe_tx against a cycle trace model.
module tb_latch_strobe_tx;
    import latch_tx_pkg::*;

    typedef struct packed {
        logic en;
        logic a;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a, valid_a, ready_a, a_a, en_a, busy_a, done_a;
    logic [7:0] data_a;
    logic       rst_b, valid_b, ready_b, a_b, en_b, busy_b, done_b;
    logic [3:0] data_b;
    logic       lat0, lat1, lat2, lat3;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    latch_strobe_tx #(
        .WIDTH(8), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .MSB_FIRST(1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_valid(valid_a), .i_data(data_a),
        .o_ready(ready_a), .o_a(a_a), .o_en(en_a), .o_busy(busy_a), .o_done(done_a)
    );

    latch_strobe_tx #(
        .WIDTH(4), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1), .MSB_FIRST(0)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_b), .i_valid(valid_b), .i_data(data_b),
        .o_ready(ready_b), .o_a(a_b), .o_en(en_b), .o_busy(busy_b), .o_done(done_b)
    );

    // Four-level transparent-latch receive chain, all gated by the strobe.
    always_latch if (en_a) lat0 <= a_a;
    always_latch if (en_a) lat1 <= lat0;
    always_latch if (en_a) lat2 <= lat1;
    always_latch if (en_a) lat3 <= lat2;

    // Expected per-cycle outputs for one word, starting the cycle after the handshake.
    function automatic void build_trace(input int unsigned w, input int unsigned s,
                                        input int unsigned t, input int unsigned h,
                                        input int unsigned msb, input logic [31:0] d);
        logic b;
        exp_q.delete();
        for (int unsigned i = 0; i < w; i++) begin
            b = d[(msb != 0) ? (w - 1 - i) : i];
            for (int unsigned c = 0; c < s; c++) exp_q.push_back('{1'b0, b, 1'b1, 1'b0, 1'b0});
            for (int unsigned c = 0; c < t; c++) exp_q.push_back('{1'b1, b, 1'b1, 1'b0, 1'b0});
            for (int unsigned c = 0; c < h; c++) exp_q.push_back('{1'b0, b, 1'b1, 1'b0, 1'b0});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    endfunction

    // Offer a word and return #1 after the edge that accepts it.
    task automatic start_a(input logic [7:0] d, input bit hold);
        int unsigned n = 0;
        @(posedge clk); #1;
        valid_a = 1'b1;
        data_a  = d;
        @(negedge clk);
        while (!ready_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_a) begin
            n_cmp++; n_bad++;
            $display("FAIL start_a timeout: ready=%b required 1", ready_a);
        end
        @(posedge clk); #1;
        if (!hold) begin
            valid_a = 1'b0;
            data_a  = 8'($urandom);
        end
    endtask

    task automatic start_b(input logic [3:0] d);
        int unsigned n = 0;
        @(posedge clk); #1;
        valid_b = 1'b1;
        data_b  = d;
        @(negedge clk);
        while (!ready_b && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_b) begin
            n_cmp++; n_bad++;
            $display("FAIL start_b timeout: ready=%b required 1", ready_b);
        end
        @(posedge clk); #1;
        valid_b = 1'b0;
        data_b  = 4'($urandom);
    endtask

    task automatic test_reset;
        exp_t obs;
        rst_a = 1'b0; rst_b = 1'b0;
        valid_a = 1'b0; valid_b = 1'b0;
        data_a = '0; data_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        obs = {en_a, a_a, busy_a, done_a, ready_a};
        n_cmp++;
        if (obs !== 5'b00000) begin n_bad++; $display("FAIL reset_a: got %b want 00000", obs); end
        obs = {en_b, a_b, busy_b, done_b, ready_b};
        n_cmp++;
        if (obs !== 5'b00000) begin n_bad++; $display("FAIL reset_b: got %b want 00000", obs); end
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready_a !== 1'b0) begin n_bad++; $display("FAIL release_early: ready=%b want 0", ready_a); end
        @(negedge clk);
        n_cmp++;
        if (ready_a !== 1'b1) begin n_bad++; $display("FAIL release_ready_a: ready=%b want 1", ready_a); end
        n_cmp++;
        if (ready_b !== 1'b1) begin n_bad++; $display("FAIL release_ready_b: ready=%b want 1", ready_b); end
    endtask

    task automatic test_serialize;
        exp_t       obs;
        logic [7:0] words[6];
        words[0] = 8'hA5;
        for (int i = 1; i < 6; i++) words[i] = 8'($urandom);
        for (int w = 0; w < 6; w++) begin
            build_trace(8, 1, 1, 1, 1, {24'd0, words[w]});
            repeat ($urandom_range(0, 3)) @(posedge clk);
            start_a(words[w], 1'b0);
            for (int j = 0; j < exp_q.size(); j++) begin
                @(negedge clk);
                obs = {en_a, a_a, busy_a, done_a, ready_a};
                n_cmp++;
                if (obs !== exp_q[j]) begin
                    n_bad++;
                    $display("FAIL serialize %h cycle k+%0d: got %b want %b", words[w], j + 1, obs, exp_q[j]);
                end
                if (j > 0 && exp_q[j-1].en && !exp_q[j].en) begin
                    n_cmp++;
                    if ({lat3, lat2, lat1, lat0} !== {4{exp_q[j].a}}) begin
                        n_bad++;
                        $display("FAIL latch_chain %h cycle k+%0d: got %b want %b",
                                 words[w], j + 1, {lat3, lat2, lat1, lat0}, {4{exp_q[j].a}});
                    end
                end
            end
            @(negedge clk);
            obs = {en_a, a_a, busy_a, done_a, ready_a};
            n_cmp++;
            if (obs !== 5'b00001) begin n_bad++; $display("FAIL idle_after %h: got %b want 00001", words[w], obs); end
        end
    endtask

    task automatic test_back_to_back;
        exp_t obs;
        int   done_cyc[2];
        build_trace(8, 1, 1, 1, 1, 32'hFF);
        start_a(8'hFF, 1'b1);
        data_a = 8'h00;
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            obs = {en_a, a_a, busy_a, done_a, ready_a};
            n_cmp++;
            if (obs !== exp_q[j]) begin n_bad++; $display("FAIL b2b_ff cycle k+%0d: got %b want %b", j + 1, obs, exp_q[j]); end
            if (done_a) done_cyc[0] = cyc;
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
        build_trace(8, 1, 1, 1, 1, 32'h00);
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            obs = {en_a, a_a, busy_a, done_a, ready_a};
            n_cmp++;
            if (obs !== exp_q[j]) begin n_bad++; $display("FAIL b2b_00 cycle %0d: got %b want %b", j, obs, exp_q[j]); end
            if (done_a) done_cyc[1] = cyc;
        end
        n_cmp++;
        if (done_cyc[1] - done_cyc[0] !== int'(word_period(8, 1, 1, 1))) begin
            n_bad++;
            $display("FAIL b2b_period: got %0d want %0d", done_cyc[1] - done_cyc[0], word_period(8, 1, 1, 1));
        end
    endtask

    task automatic test_data_hold;
        exp_t       obs;
        logic [7:0] d0, d1;
        d0 = 8'($urandom);
        build_trace(8, 1, 1, 1, 1, {24'd0, d0});
        start_a(d0, 1'b1);
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            obs = {en_a, a_a, busy_a, done_a, ready_a};
            n_cmp++;
            if (obs !== exp_q[j]) begin n_bad++; $display("FAIL data_hold %h cycle k+%0d: got %b want %b", d0, j + 1, obs, exp_q[j]); end
            if (j < exp_q.size() - 1) begin
                @(posedge clk); #1;
                data_a = 8'($urandom);
            end
        end
        d1 = data_a;
        @(posedge clk); #1;
        valid_a = 1'b0;
        data_a  = 8'($urandom);
        build_trace(8, 1, 1, 1, 1, {24'd0, d1});
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            obs = {en_a, a_a, busy_a, done_a, ready_a};
            n_cmp++;
            if (obs !== exp_q[j]) begin n_bad++; $display("FAIL data_hold2 %h cycle %0d: got %b want %b", d1, j, obs, exp_q[j]); end
        end
    endtask

    task automatic test_reset_mid;
        exp_t       obs;
        logic [7:0] d;
        d = 8'($urandom);
        build_trace(8, 1, 1, 1, 1, {24'd0, d});
        start_a(d, 1'b0);
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            obs = {en_a, a_a, busy_a, done_a, ready_a};
            n_cmp++;
            if (obs !== exp_q[j]) begin n_bad++; $display("FAIL pre_reset cycle k+%0d: got %b want %b", j + 1, obs, exp_q[j]); end
        end
        rst_a = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            obs = {en_a, a_a, busy_a, done_a, ready_a};
            n_cmp++;
            if (obs !== 5'b00000) begin n_bad++; $display("FAIL mid_reset %0d: got %b want 00000", j, obs); end
        end
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({done_a, ready_a} !== 2'b00) begin n_bad++; $display("FAIL post_reset_early: got %b want 00", {done_a, ready_a}); end
        @(negedge clk);
        obs = {en_a, a_a, busy_a, done_a, ready_a};
        n_cmp++;
        if (obs !== 5'b00001) begin n_bad++; $display("FAIL post_reset_ready: got %b want 00001", obs); end
        build_trace(8, 1, 1, 1, 1, 32'h3C);
        start_a(8'h3C, 1'b0);
        for (int j = 0; j < exp_q.size(); j++) begin
            @(negedge clk);
            obs = {en_a, a_a, busy_a, done_a, ready_a};
            n_cmp++;
            if (obs !== exp_q[j]) begin n_bad++; $display("FAIL after_reset_3c cycle k+%0d: got %b want %b", j + 1, obs, exp_q[j]); end
        end
    endtask

    task automatic test_lsb_wide_phases;
        exp_t       obs;
        logic [3:0] words[4];
        words[0] = 4'h6;
        for (int i = 1; i < 4; i++) words[i] = 4'($urandom);
        for (int w = 0; w < 4; w++) begin
            build_trace(4, 2, 3, 1, 0, {28'd0, words[w]});
            start_b(words[w]);
            for (int j = 0; j < exp_q.size(); j++) begin
                @(negedge clk);
                obs = {en_b, a_b, busy_b, done_b, ready_b};
                n_cmp++;
                if (obs !== exp_q[j]) begin
                    n_bad++;
                    $display("FAIL lsb %h cycle k+%0d: got %b want %b", words[w], j + 1, obs, exp_q[j]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_serialize();
        test_back_to_back();
        test_data_hold();
        test_reset_mid();
        test_lsb_wide_phases();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/latch_strobe_tx.md
Name: latch_strobe_tx

Overview:
- Transmitter for the scalar latch-port interface: a data line plus a level enable strobe, feeding a transparent-latch receive chain (G = enable, D = data).
- Accepts a parallel word over a valid/ready handshake and serializes it one bit per strobe.
- Holds data stable before, during and after each strobe so every latch in the receive hierarchy captures cleanly.
- Sits at the stimulus/driver end of the latch-port path in the top-level harness.

Parameters:
- WIDTH, 8: bits per word; legal range 1..32.
- SETUP_CYC, 1: cycles o_a is stable with o_en low before each strobe; must be >= 1.
- STROBE_CYC, 1: cycles o_en is high per bit; must be >= 1.
- HOLD_CYC, 1: cycles o_a is held with o_en low after each strobe; must be >= 1.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_valid  input  1  word offered.
- i_data  input  WIDTH  word to send; sampled only on handshake.
- o_ready  output  1  transmitter can accept a word.
- o_a  output  1  serial data to the latch D input.
- o_en  output  1  latch enable strobe (G).
- o_busy  output  1  word in flight.
- o_done  output  1  one-cycle pulse after the last bit's hold phase.

Behaviour:
- Single clock i_clk. Reset is synchronous and active-low on i_rst_n. All outputs are registered.
- Reset values: o_ready=0, o_a=0, o_en=0, o_busy=0, o_done=0, state=IDLE. o_ready rises on the first edge after i_rst_n=1 is sampled.
- States:
  - IDLE: o_ready=1, o_a=0, o_en=0.
  - SETUP, STROBE, HOLD: per-bit phases.
  - DONE: one cycle; o_done=1 and o_ready=1.
- Handshake: a word is accepted on an edge where i_valid & o_ready. i_data is loaded into the shift register and the bit counter is cleared.
- i_valid while o_ready=0 is ignored; i_data changes during busy have no effect.
- Transitions:
  - IDLE -> SETUP on handshake.
  - SETUP -> STROBE after SETUP_CYC cycles.
  - STROBE -> HOLD after STROBE_CYC cycles.
  - HOLD -> SETUP for the next bit after HOLD_CYC cycles, or HOLD -> DONE after the last bit.
  - DONE -> SETUP on handshake in the DONE cycle (back-to-back); otherwise DONE -> IDLE.
- o_a is constant through SETUP, STROBE and HOLD of a bit. It changes only on the SETUP entry edge, never while o_en=1.
- o_en=1 only in STROBE; o_busy=1 in SETUP, STROBE and HOLD.
- Latency: handshake at edge k gives the first SETUP cycle k+1 and o_done in cycle k+1+WIDTH*(SETUP_CYC+STROBE_CYC+HOLD_CYC).
- Back-to-back word period is WIDTH*(S+T+H)+1 cycles.
- Bit counter width is $clog2(WIDTH+1); the phase counter width is sized for max(S,T,H). No wrap: the counter saturates at WIDTH and then goes to DONE.
- Reset mid-word: at the reset edge all outputs go 0 (o_en drops with no glitch cycle high). The partial word is discarded and no o_done is generated.
- WIDTH=1: a single SETUP/STROBE/HOLD sequence, then DONE.

Decomposition:
- Package latch_tx_pkg holds:
  - state enum typedef (IDLE, SETUP, STROBE, HOLD, DONE);
  - default phase-length constants;
  - a function computing word period from the parameters, used by both RTL assertions and the bench.
- One sub-module, latch_tx_phase_timer: a loadable down-counter with a zero flag, reused for all three phase lengths.

Test Plan:
- WIDTH=8, S=T=H=1, MSB_FIRST=1, send 0xA5 at edge k -> o_en high in cycles k+2, k+5, ..., k+23. o_a during the strobes is 1,0,1,0,0,1,0,1. o_done=1 only in cycle k+25.
- Back-to-back 0xFF then 0x00, second i_valid held high -> second word accepted in the DONE cycle k+25. Its first strobe is at k+27. No IDLE cycle appears and o_ready is 0 throughout each word.
- WIDTH=4, S=2, T=3, H=1, MSB_FIRST=0, send 0x6 -> bit order 0,1,1,0. Each strobe is 3 cycles high, each bit lasts 6 cycles, o_done at k+25. o_a never toggles while o_en=1 (assertion).
- Reset (i_rst_n=0) during bit 3's strobe -> next edge o_en=0, o_busy=0, o_ready=0, no o_done. After release, o_ready=1 one cycle later and a new word 0x3C is sent intact.
- i_valid held with i_data changing every cycle while busy -> only the word captured at the handshake is transmitted.
- Drive o_a/o_en into a behavioural transparent-latch chain 4 levels deep -> after each strobe falls, every latch output equals the transmitted bit.
